// File: rtl/xor_share_arbiter.sv
// xor_share_arbiter
// Shares one external 1-bit EXOR between N_REQ requesters. The winning
// requester's operands are streamed LSB-first through the EXOR over WIDTH
// cycles. The result is returned on a valid/ready channel, tagged with the
// requester index.
// Build option: define XOR_ARB_RR_EN for round-robin arbitration. When it is
// undefined, arbitration is fixed priority and the lowest index wins.
module xor_share_arbiter #(
    parameter int N_REQ = 4,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [N_REQ-1:0]           req_valid,
    output logic [N_REQ-1:0]           req_ready,
    input  logic [N_REQ*WIDTH-1:0]     req_a,
    input  logic [N_REQ*WIDTH-1:0]     req_b,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [WIDTH-1:0]           rsp_data,
    output logic [$clog2(N_REQ)-1:0]   rsp_id,
    output logic                       busy,
    output logic                       xor_in1,
    output logic                       xor_in2,
    input  logic                       xor_out
);
    localparam int ID_W  = $clog2(N_REQ);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic             rsp_valid_q, rsp_valid_d;
    logic             busy_q, busy_d;

    logic             found;
    logic [ID_W-1:0]  win;
    logic [ID_W-1:0]  cand;
    logic             accept;

`ifdef XOR_ARB_RR_EN
    logic [ID_W-1:0]  ptr_q, ptr_d;

    // Round-robin search: the first valid requester after the last winner.
    always_comb begin
        // NOTE: every signal gets a default before any branch; a path that
        // leaves a combinational output unassigned would infer a latch.
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 1; k <= N_REQ; k++) begin
            cand = ID_W'((int'(ptr_q) + k) % N_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
        ptr_d = accept ? win : ptr_q;
    end

    // Pointer register. After reset it points at the last index, so
    // requester 0 wins first.
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= ID_W'(N_REQ - 1);
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: the lowest valid index wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = '0;
        for (int k = 0; k < N_REQ; k++) begin
            cand = ID_W'(k);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end
`endif

    // Combinational grant. It is only given in IDLE and is held off during reset.
    always_comb begin
        req_ready = '0;
        accept    = 1'b0;
        if (state_q == IDLE && !rst && found) begin
            req_ready[win] = 1'b1;
            accept         = 1'b1;
        end
    end

    // Next-state logic: capture on accept, stream bits in SHIFT, hold in DONE.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_d       = res_q;
        id_d        = id_q;
        rsp_valid_d = rsp_valid_q;
        busy_d      = busy_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = SHIFT;
                    cnt_d   = '0;
                    a_sh_d  = req_a[int'(win)*WIDTH +: WIDTH];
                    b_sh_d  = req_b[int'(win)*WIDTH +: WIDTH];
                    id_d    = win;
                    busy_d  = 1'b1;
                end
            end
            SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                // Each EXOR result enters at the MSB. After WIDTH shifts,
                // bit k holds a[k]^b[k].
                res_d            = res_q >> 1;
                res_d[WIDTH-1]   = xor_out;
                if (cnt_q == CNT_LAST) begin
                    state_d     = DONE;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (rsp_ready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b0;
                    busy_d      = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Controller registers. Reset discards any operation in flight.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments, so every flop
        // samples the values from before the edge, whatever the statement order.
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_q       <= '0;
            id_q        <= '0;
            rsp_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_q       <= res_d;
            id_q        <= id_d;
            rsp_valid_q <= rsp_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = res_q;
    assign rsp_id    = id_q;
    assign busy      = busy_q;
    assign xor_in1   = (state_q == SHIFT) & a_sh_q[0];
    assign xor_in2   = (state_q == SHIFT) & b_sh_q[0];
endmodule

// File: tb/tb_xor_share_arbiter.sv
// Testbench for xor_share_arbiter. It compares the DUT every cycle with a
// transaction-level model: a record of the operation in flight, plus the
// number of cycles since its accept.
module tb_xor_share_arbiter;
    localparam int N_REQ = 4;
    localparam int WIDTH = 8;
    localparam int ID_W  = $clog2(N_REQ);

    logic                     clk = 1'b0;
    logic                     rst = 1'b1;
    logic [N_REQ-1:0]         req_valid = '0;
    logic [N_REQ-1:0]         req_ready;
    logic [N_REQ*WIDTH-1:0]   req_a = '0;
    logic [N_REQ*WIDTH-1:0]   req_b = '0;
    logic                     rsp_valid;
    logic                     rsp_ready = 1'b0;
    logic [WIDTH-1:0]         rsp_data;
    logic [ID_W-1:0]          rsp_id;
    logic                     busy;
    logic                     xor_in1, xor_in2, xor_out;

    xor_share_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(rsp_data), .rsp_id(rsp_id), .busy(busy),
        .xor_in1(xor_in1), .xor_in2(xor_in2), .xor_out(xor_out)
    );

    // The external EXOR instance.
    assign xor_out = xor_in1 ^ xor_in2;

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Requester front-ends: pending requests and their held operands.
    bit               pend[N_REQ];
    logic [WIDTH-1:0] pa[N_REQ];
    logic [WIDTH-1:0] pb[N_REQ];
    bit               rearm = 0;

    // Model of the operation in flight.
    bit               m_busy = 0;
    int               m_k = 0;
    logic [WIDTH-1:0] m_a, m_b;
    int               m_id = 0;
    int               m_last = N_REQ - 1;
    bit               zero_known = 1;

    // Logs and timestamps taken from the cycle loop.
    int               cycle = 0;
    int               grants[$];
    int               acc_cycles[$];
    logic [WIDTH-1:0] rsp_log[$];
    int               rsp_id_log[$];
    int               rise_cycle = -1;
    int               hs_cycle = -1;
    bit               prev_valid = 0;

    function automatic int pick(input int last);
`ifdef XOR_ARB_RR_EN
        for (int k = 1; k <= N_REQ; k++)
            if (pend[(last + k) % N_REQ]) return (last + k) % N_REQ;
`else
        for (int k = 0; k < N_REQ; k++)
            if (pend[k]) return k;
`endif
        return -1;
    endfunction

    // One clock cycle: drive inputs, check the outputs, then advance the model.
    task automatic step(input bit rdy, input bit do_rst);
        int w;
        logic [31:0] exp_rdy;
        @(negedge clk);
        for (int i = 0; i < N_REQ; i++) begin
            req_valid[i]               = pend[i];
            req_a[i*WIDTH +: WIDTH]    = pa[i];
            req_b[i*WIDTH +: WIDTH]    = pb[i];
        end
        rsp_ready = rdy;
        rst       = do_rst;
        #1;
        w = m_busy ? -1 : pick(m_last);
        exp_rdy = (do_rst || w < 0) ? 32'd0 : (32'd1 << w);
        check("req_ready", req_ready, exp_rdy);
        if (!do_rst) begin
            check("busy", busy, m_busy);
            check("rsp_valid", rsp_valid, m_busy && m_k == WIDTH + 1);
            if (m_busy && m_k <= WIDTH) begin
                check("xor_in1", xor_in1, m_a[m_k-1]);
                check("xor_in2", xor_in2, m_b[m_k-1]);
            end else begin
                check("xor_in1", xor_in1, 0);
                check("xor_in2", xor_in2, 0);
            end
            if (m_busy && m_k == WIDTH + 1) begin
                check("rsp_data", rsp_data, m_a ^ m_b);
                check("rsp_id", rsp_id, m_id);
            end else if (!m_busy && zero_known) begin
                check("rsp_data_rst", rsp_data, 0);
                check("rsp_id_rst", rsp_id, 0);
            end
            if (req_ready != '0) acc_cycles.push_back(cycle);
            if (rsp_valid && !prev_valid) rise_cycle = cycle;
            if (rsp_valid && rdy) begin
                hs_cycle = cycle;
                rsp_log.push_back(rsp_data);
                rsp_id_log.push_back(int'(rsp_id));
            end
            prev_valid = rsp_valid;
        end else begin
            prev_valid = 0;
        end
        @(posedge clk);
        cycle++;
        if (do_rst) begin
            m_busy     = 0;
            m_last     = N_REQ - 1;
            zero_known = 1;
        end else if (!m_busy) begin
            if (w >= 0) begin
                m_busy = 1;
                m_k    = 1;
                m_a    = pa[w];
                m_b    = pb[w];
                m_id   = w;
                m_last = w;
                zero_known = 0;
                grants.push_back(w);
                if (rearm) begin
                    pa[w] = WIDTH'($urandom);
                    pb[w] = WIDTH'($urandom);
                end else begin
                    pend[w] = 0;
                end
            end
        end else if (m_k <= WIDTH) begin
            m_k++;
        end else if (rdy) begin
            m_busy = 0;
        end
    endtask

    task automatic reset_all();
        for (int i = 0; i < N_REQ; i++) begin
            pend[i] = 0;
            pa[i]   = '0;
            pb[i]   = '0;
        end
        rearm = 0;
        step(1, 1);
        step(1, 1);
        grants.delete();
        acc_cycles.delete();
        rsp_log.delete();
        rsp_id_log.delete();
    endtask

    task automatic post(input int id, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        pend[id] = 1;
        pa[id]   = a;
        pb[id]   = b;
    endtask

    initial begin
        int n;
        // 1: a single request on requester 0, then the reset state and latency
        reset_all();
        post(0, 8'hA5, 8'h0F);
        for (int i = 0; i < 14; i++) step(1, 0);
        check("t1_nrsp", rsp_log.size(), 1);
        if (rsp_log.size() >= 1) begin
            check("t1_data", rsp_log[0], 8'hAA);
            check("t1_id", rsp_id_log[0], 0);
        end
        if (acc_cycles.size() >= 1)
            check("t1_latency", rise_cycle - acc_cycles[0], WIDTH + 1);
        else
            check("t1_accept_seen", acc_cycles.size(), 1);

        // 2: all requesters valid and held, with distinct operands
        reset_all();
        for (int i = 0; i < N_REQ; i++) post(i, WIDTH'(8'h11 * (i + 1)), WIDTH'(8'h3C + i));
        rearm = 1;
        for (int i = 0; i < 5 * (WIDTH + 2) - 2; i++) step(1, 0);
        rearm = 0;
        check("t2_ngrants", grants.size() >= 5, 1);
        n = (grants.size() < 5) ? grants.size() : 5;
        for (int i = 0; i < n; i++) begin
`ifdef XOR_ARB_RR_EN
            check("t2_order", grants[i], i % N_REQ);
`else
            check("t2_order", grants[i], 0);
`endif
        end
        for (int i = 1; i < acc_cycles.size() && i < 5; i++)
            check("t2_spacing", acc_cycles[i] - acc_cycles[i-1], WIDTH + 2);

        // 3: backpressure in DONE, with a new request waiting
        reset_all();
        post(1, 8'h5A, 8'hC3);
        for (int i = 0; i < 40 && !(m_busy && m_k == WIDTH + 1); i++) step(1, 0);
        post(2, 8'h77, 8'h01);
        for (int i = 0; i < 5; i++) step(0, 0);
        step(1, 0);
        step(1, 0);
        check("t3_rsp_data", (rsp_log.size() >= 1) ? rsp_log[0] : 8'h00, 8'h99);
        check("t3_accept_after_hs",
              (acc_cycles.size() >= 2) ? acc_cycles[1] - hs_cycle : -1, 1);
        check("t3_second_grant", (grants.size() >= 2) ? grants[1] : -1, 2);
        for (int i = 0; i < WIDTH + 4; i++) step(1, 0);

        // 4: reset pulsed in SHIFT at bit 3; no response may follow
        reset_all();
        post(0, 8'hFF, 8'h00);
        for (int i = 0; i < 20 && !(m_busy && m_k == 4); i++) step(1, 0);
        step(1, 1);
        grants.delete();
        check("t4_no_rsp_pre", rsp_log.size(), 0);
        post(2, 8'h0F, 8'hF0);
        post(3, 8'h33, 8'h33);
        for (int i = 0; i < WIDTH + 4; i++) step(1, 0);
        check("t4_first_grant", (grants.size() >= 1) ? grants[0] : -1, 2);
        check("t4_rsp_id", (rsp_id_log.size() >= 1) ? rsp_id_log[0] : -1, 2);
        check("t4_rsp_data", (rsp_log.size() >= 1) ? rsp_log[0] : 8'h00, 8'hFF);
        for (int i = 0; i < 2 * (WIDTH + 2); i++) step(1, 0);

        // 5: requesters 1 and 3 held valid
        reset_all();
        post(1, 8'h12, 8'h34);
        post(3, 8'h56, 8'h78);
        rearm = 1;
        for (int i = 0; i < 4 * (WIDTH + 2); i++) step(1, 0);
        rearm = 0;
        check("t5_ngrants", grants.size() >= 4, 1);
        n = (grants.size() < 4) ? grants.size() : 4;
        for (int i = 0; i < n; i++) begin
`ifdef XOR_ARB_RR_EN
            check("t5_grant", grants[i], (i % 2 == 0) ? 1 : 3);
`else
            check("t5_grant", grants[i], 1);
`endif
        end

        // 6: edge operands
        reset_all();
        post(0, 8'hFF, 8'hFF);
        for (int i = 0; i < WIDTH + 3; i++) step(1, 0);
        post(0, 8'h00, 8'hFF);
        for (int i = 0; i < WIDTH + 3; i++) step(1, 0);
        check("t6_n", rsp_log.size(), 2);
        check("t6_ff_ff", (rsp_log.size() >= 1) ? rsp_log[0] : 8'h55, 8'h00);
        check("t6_00_ff", (rsp_log.size() >= 2) ? rsp_log[1] : 8'h55, 8'hFF);

        // Random traffic: new requests, backpressure, occasional resets
        reset_all();
        for (int c = 0; c < 800; c++) begin
            for (int i = 0; i < N_REQ; i++)
                if (!pend[i] && $urandom_range(3) == 0)
                    post(i, WIDTH'($urandom), WIDTH'($urandom));
            step($urandom_range(3) != 0, $urandom_range(149) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
